// File: rtl/alu_regfile_pipe_pkg.sv
// Shared opcode encoding and operand-usage helpers for the two-stage ALU/regfile pipe.
package ALU_REGFILE_defs;

    localparam int ALU_PIPE_OP_WIDTH = 3;

    typedef enum logic [ALU_PIPE_OP_WIDTH-1:0] {
        ADD  = 3'd0,
        ADDC = 3'd1,
        SUB  = 3'd2,
        AND  = 3'd3,
        OR   = 3'd4,
        XOR  = 3'd5,
        LDI  = 3'd6,
        PASS = 3'd7
    } alu_pipe_op_t;

    function automatic logic op_sets_carry(input alu_pipe_op_t op);
        return (op == ADD) || (op == ADDC) || (op == SUB);
    endfunction

    function automatic logic op_reads_a(input alu_pipe_op_t op);
        return op != LDI;
    endfunction

    function automatic logic op_reads_b(input alu_pipe_op_t op);
        return (op != LDI) && (op != PASS);
    endfunction

endpackage

// File: rtl/alu_pipe_regfile.sv
// Register file with two read ports and one write port; R0 is hardwired to zero and a
// same-cycle write to the register being read is bypassed onto the read data.
module alu_pipe_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 16,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b_i,
    output logic [DATA_WIDTH-1:0] rd_data_a_o,
    output logic [DATA_WIDTH-1:0] rd_data_b_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  wr_live;

    assign wr_live = wr_en_i && (wr_addr_i != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_live) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_a_o = '0;
        rd_data_b_o = '0;
        if (rd_addr_a_i != '0) begin
            rd_data_a_o = (wr_live && wr_addr_i == rd_addr_a_i) ? wr_data_i : regs_q[rd_addr_a_i];
        end
        if (rd_addr_b_i != '0) begin
            rd_data_b_o = (wr_live && wr_addr_i == rd_addr_b_i) ? wr_data_i : regs_q[rd_addr_b_i];
        end
    end

endmodule

// File: rtl/alu_regfile_pipe.sv
// Two-stage ALU + regfile pipe (issue, execute/writeback) with valid/ready on both sides.
// Define ALU_PIPE_FWD_EN to forward the EX result/carry instead of stalling on hazards.
module alu_regfile_pipe
    import ALU_REGFILE_defs::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 16,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         In_Valid,
    output logic                         In_Ready,
    input  logic [ALU_PIPE_OP_WIDTH-1:0] In_Opcode,
    input  logic [ADDR_WIDTH-1:0]        In_Src_A,
    input  logic [ADDR_WIDTH-1:0]        In_Src_B,
    input  logic [ADDR_WIDTH-1:0]        In_Dest,
    input  logic                         In_Wr_En,
    input  logic [DATA_WIDTH-1:0]        In_Imm,
    output logic                         Out_Valid,
    input  logic                         Out_Ready,
    output logic [DATA_WIDTH-1:0]        Out_Data,
    output logic                         Out_Carry,
    output logic                         Out_Zero,
    output logic [ADDR_WIDTH-1:0]        Out_Dest
);

    logic                  ex_valid_q, ex_valid_d, ex_wr_q, ex_cin_q;
    alu_pipe_op_t          ex_op_q;
    logic [DATA_WIDTH-1:0] ex_a_q, ex_b_q;
    logic [ADDR_WIDTH-1:0] ex_dest_q;
    logic                  out_valid_q, out_valid_d, out_carry_q, out_zero_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [ADDR_WIDTH-1:0] out_dest_q;
    logic                  carry_q, carry_d;

    alu_pipe_op_t          in_op;
    logic [DATA_WIDTH-1:0] rd_a, rd_b, opnd_a, opnd_b, alu_res;
    logic [DATA_WIDTH:0]   alu_wide;
    logic                  alu_carry, opnd_cin, ex_advance, accept;
    logic                  ex_writes, haz_a, haz_b, carry_haz, hazard_stall;

    assign in_op = alu_pipe_op_t'(In_Opcode);

    alu_pipe_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_regfile (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .rd_addr_a_i(In_Src_A),
        .rd_addr_b_i(In_Src_B),
        .rd_data_a_o(rd_a),
        .rd_data_b_o(rd_b),
        .wr_en_i    (ex_advance && ex_wr_q),
        .wr_addr_i  (ex_dest_q),
        .wr_data_i  (alu_res)
    );

    // EX ALU; LDI's immediate travels in the B operand register.
    always_comb begin
        alu_wide = '0;
        unique case (ex_op_q)
            ADD:  alu_wide = {1'b0, ex_a_q} + {1'b0, ex_b_q};
            ADDC: alu_wide = {1'b0, ex_a_q} + {1'b0, ex_b_q} + {{DATA_WIDTH{1'b0}}, ex_cin_q};
            SUB:  alu_wide = {1'b0, ex_a_q} - {1'b0, ex_b_q};
            AND:  alu_wide = {1'b0, ex_a_q & ex_b_q};
            OR:   alu_wide = {1'b0, ex_a_q | ex_b_q};
            XOR:  alu_wide = {1'b0, ex_a_q ^ ex_b_q};
            LDI:  alu_wide = {1'b0, ex_b_q};
            PASS: alu_wide = {1'b0, ex_a_q};
            default: alu_wide = '0;
        endcase
    end

    assign alu_res    = alu_wide[DATA_WIDTH-1:0];
    assign alu_carry  = op_sets_carry(ex_op_q) && alu_wide[DATA_WIDTH];
    assign ex_advance = ex_valid_q && (!out_valid_q || Out_Ready);

    assign ex_writes = ex_valid_q && ex_wr_q && (ex_dest_q != '0);
    assign haz_a     = ex_writes && op_reads_a(in_op) && (In_Src_A == ex_dest_q);
    assign haz_b     = ex_writes && op_reads_b(in_op) && (In_Src_B == ex_dest_q);
    assign carry_haz = ex_valid_q && (in_op == ADDC) && op_sets_carry(ex_op_q);

    always_comb begin
`ifdef ALU_PIPE_FWD_EN
        hazard_stall = 1'b0;
        opnd_a       = haz_a ? alu_res : rd_a;
        opnd_b       = haz_b ? alu_res : rd_b;
        opnd_cin     = carry_haz ? alu_carry : carry_q;
`else
        hazard_stall = haz_a || haz_b || carry_haz;
        opnd_a       = rd_a;
        opnd_b       = rd_b;
        opnd_cin     = carry_q;
`endif
        if (in_op == LDI) begin
            opnd_b = In_Imm;
        end
    end

    assign In_Ready = !Reset && (!ex_valid_q || ex_advance) && !hazard_stall;
    assign accept   = In_Valid && In_Ready;

    always_comb begin
        ex_valid_d  = accept ? 1'b1 : (ex_advance ? 1'b0 : ex_valid_q);
        out_valid_d = ex_advance ? 1'b1 : (Out_Ready ? 1'b0 : out_valid_q);
        carry_d     = (ex_advance && op_sets_carry(ex_op_q)) ? alu_carry : carry_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ex_valid_q  <= 1'b0;
            ex_op_q     <= ADD;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_dest_q   <= '0;
            ex_wr_q     <= 1'b0;
            ex_cin_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_carry_q <= 1'b0;
            out_zero_q  <= 1'b0;
            out_dest_q  <= '0;
            carry_q     <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
            if (accept) begin
                ex_op_q   <= in_op;
                ex_a_q    <= opnd_a;
                ex_b_q    <= opnd_b;
                ex_dest_q <= In_Dest;
                ex_wr_q   <= In_Wr_En;
                ex_cin_q  <= opnd_cin;
            end
            if (ex_advance) begin
                out_data_q  <= alu_res;
                out_carry_q <= alu_carry;
                out_zero_q  <= (alu_res == '0);
                out_dest_q  <= ex_dest_q;
            end
        end
    end

    assign Out_Valid = out_valid_q;
    assign Out_Data  = out_data_q;
    assign Out_Carry = out_carry_q;
    assign Out_Zero  = out_zero_q;
    assign Out_Dest  = out_dest_q;

endmodule
